par_check_rx: RTL and testbench

Serial parity-checking receiver that sits directly downstream of the parity generator. It accepts a framed serial stream, one bit per `bit_en` strobe: a start bit, DATA_W data bits LSB-first, the parity bit produced by the generator, and a stop bit. It reassembles the data word, recomputes parity, and reports the word with a one-cycle valid pulse plus parity-error and framing-error flags.

---
 rtl/par_check_rx.sv | 98 +++++++++
 tb/tb_par_check_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/par_check_rx.sv
// Serial parity-checking receiver: start bit, DATA_W data bits LSB-first,
// parity bit, stop bit; one bit per bit_en strobe.
module par_check_rx #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic              start_clr, shift_en, par_en, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_clr = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (bit_en && !sin) begin
        start_clr = 1'b1;
        state_d   = DATA;
      end
      DATA: if (bit_en) begin
        shift_en = 1'b1;
        if (cnt == LAST_BIT) state_d = PAR;
      end
      PAR: if (bit_en) begin
        par_en  = 1'b1;
        state_d = STOP;
      end
      STOP: if (bit_en) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and running parity are cleared on the start strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      par_acc <= 1'b0;
    end else begin
      if (start_clr)     cnt <= '0;
      else if (shift_en) cnt <= cnt + CNT_W'(1);
      if (start_clr)                 par_acc <= 1'b0;
      else if (shift_en || par_en)   par_acc <= par_acc ^ sin;
    end
  end

  // Shift register is pure data and carries no reset
  always_ff @(posedge clk) begin
    if (shift_en) shreg[cnt] <= sin;
  end

  // Frame completion: outputs register on the stop strobe and hold until the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      dout_valid <= done;
      if (done) begin
        dout    <= shreg;
        par_err <= par_acc ^ ODD;
        frm_err <= ~sin;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_par_check_rx.sv
// Directed bench for par_check_rx: table of frames plus hand-written
// sequences for busy timing, sparse strobes, back-to-back frames and reset.
module tb_par_check_rx;

  logic clk = 1'b0;
  logic rst, bit_en, sin;
  logic [2:0] dout_e, dout_o;
  logic v_e, v_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  always #5 clk = ~clk;

  par_check_rx #(.DATA_W(3), .ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .dout(dout_e),
    .dout_valid(v_e), .par_err(pe_e), .frm_err(fe_e), .busy(busy_e));

  par_check_rx #(.DATA_W(3), .ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .dout(dout_o),
    .dout_valid(v_o), .par_err(pe_o), .frm_err(fe_o), .busy(busy_o));

  typedef struct packed {logic [2:0] d; logic p; logic f;} rec_t;
  typedef struct {
    logic [2:0] word; logic par; logic stop;
    logic [2:0] exp_d; logic exp_p; logic exp_f;
  } vec_t;

  rec_t q_e[$], q_o[$];
  rec_t r;
  vec_t tbl[17];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Capture every completed frame; busy must already be low while dout_valid is high
  always @(negedge clk) begin
    if (v_e) begin
      q_e.push_back({dout_e, pe_e, fe_e});
      chk("busy_low_at_valid", {7'd0, busy_e}, 8'd0);
    end
    if (v_o) q_o.push_back({dout_o, pe_o, fe_o});
  end

  task automatic send_bit(input logic b, input int gap);
    @(negedge clk); bit_en = 1'b1; sin = b;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk); bit_en = 1'b0; sin = ~sin;
    end
  endtask

  task automatic send_frame(input logic [2:0] w, input logic p, input logic s, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 3; i++) send_bit(w[i], gap);
    send_bit(p, gap);
    send_bit(s, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); bit_en = 1'b0; sin = 1'b1;
    end
  endtask

  task automatic chk_frame(input string name, input logic [2:0] d, input logic p, input logic f);
    chk({name, "_count"}, 8'(q_e.size()), 8'd1);
    if (q_e.size() > 0) begin
      r = q_e.pop_front();
      chk({name, "_dout"}, {5'd0, r.d}, {5'd0, d});
      chk({name, "_par_err"}, {7'd0, r.p}, {7'd0, p});
      chk({name, "_frm_err"}, {7'd0, r.f}, {7'd0, f});
    end
    q_e.delete();
    q_o.delete();
  endtask

  initial begin
    logic nom_bits [6];
    tbl[0]  = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{3'b001, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0};
    tbl[2]  = '{3'b010, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0};
    tbl[3]  = '{3'b011, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0};
    tbl[4]  = '{3'b100, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0};
    tbl[5]  = '{3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0};
    tbl[6]  = '{3'b110, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0};
    tbl[7]  = '{3'b111, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0};
    tbl[8]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0};
    tbl[9]  = '{3'b001, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0};
    tbl[10] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0};
    tbl[11] = '{3'b011, 1'b1, 1'b1, 3'b011, 1'b1, 1'b0};
    tbl[12] = '{3'b100, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0};
    tbl[13] = '{3'b101, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0};
    tbl[14] = '{3'b110, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0};
    tbl[15] = '{3'b111, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0};
    tbl[16] = '{3'b011, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1};
    nom_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; bit_en = 1'b0; sin = 1'b1;
    #12;
    chk("rst_dout", {5'd0, dout_e}, 8'd0);
    chk("rst_ctrl", {4'd0, v_e, pe_e, fe_e, busy_e}, 8'd0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    // Nominal frame with busy tracking
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) chk("nom_busy_mid", {7'd0, busy_e}, 8'd1);
      bit_en = 1'b1; sin = nom_bits[i];
    end
    @(negedge clk); bit_en = 1'b0; sin = 1'b1;
    chk("nom_valid_after_stop", {7'd0, v_e}, 8'd1);
    chk("nom_busy_drop", {7'd0, busy_e}, 8'd0);
    @(negedge clk);
    chk("nom_valid_one_cycle", {7'd0, v_e}, 8'd0);
    idle(2);
    chk_frame("nominal", 3'b101, 1'b0, 1'b0);

    for (int t = 0; t < 17; t++) begin
      send_frame(tbl[t].word, tbl[t].par, tbl[t].stop, 0);
      idle(3);
      chk_frame($sformatf("tbl%0d", t), tbl[t].exp_d, tbl[t].exp_p, tbl[t].exp_f);
    end

    // Stop bit of 0 must not start a new frame; idle strobes follow
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    idle(2);
    chk("frm_no_new_valid", 8'(q_e.size()), 8'd0);
    chk("frm_busy_idle", {7'd0, busy_e}, 8'd0);

    // Sparse strobes, one in four, with sin toggling between strobes
    send_frame(3'b110, 1'b1, 1'b1, 3);
    idle(3);
    chk("sparse_odd_count", 8'(q_o.size()), 8'd1);
    if (q_o.size() > 0) begin
      r = q_o.pop_front();
      chk("sparse_odd_dout", {5'd0, r.d}, 8'h06);
      chk("sparse_odd_par_err", {7'd0, r.p}, 8'd0);
      chk("sparse_odd_frm_err", {7'd0, r.f}, 8'd0);
    end
    chk_frame("sparse_even", 3'b110, 1'b1, 1'b0);

    // Back-to-back frames with no idle strobe between
    send_frame(3'b001, 1'b1, 1'b1, 0);
    send_frame(3'b111, 1'b1, 1'b1, 0);
    idle(3);
    chk("b2b_count", 8'(q_e.size()), 8'd2);
    if (q_e.size() == 2) begin
      r = q_e.pop_front();
      chk("b2b_first", {3'd0, r}, {3'd0, 3'b001, 1'b0, 1'b0});
      r = q_e.pop_front();
      chk("b2b_second", {3'd0, r}, {3'd0, 3'b111, 1'b0, 1'b0});
    end
    q_e.delete(); q_o.delete();

    // Asynchronous reset after two data bits
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    @(negedge clk); bit_en = 1'b0; sin = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout", {5'd0, dout_e}, 8'd0);
    chk("midrst_ctrl", {4'd0, v_e, pe_e, fe_e, busy_e}, 8'd0);
    @(negedge clk); rst = 1'b0;
    idle(8);
    chk("midrst_no_valid", 8'(q_e.size()), 8'd0);
    send_frame(3'b100, 1'b1, 1'b1, 0);
    idle(3);
    chk_frame("after_rst", 3'b100, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
